serial_host_ctrl: RTL and testbench

//   Bus initiator for the 4-register RS-232 peripheral: data reg at 0, status reg at 1, clk_div_l at 2, clk_div_h at 3.

---
 rtl/serial_host_ctrl_if.sv | 45 ++++
 rtl/serial_host_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_serial_host_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_host_ctrl_if.sv
// Bundles the serial peripheral bus and the two byte streams of serial_host_ctrl.
// The master side is the controller; the slave side is the peripheral plus the stream partners.
interface serial_host_ctrl_if;
   // peripheral register port
   logic [1:0] s_addr;
   logic       s_en;
   logic       s_wren;
   logic       s_ren;
   logic [7:0] s_wdata;
   logic [7:0] s_rdata;
   // transmit stream (producer -> controller)
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   // receive stream (controller -> consumer)
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   // status / control
   logic       clear_flags;
   logic [1:0] ovf_flags;
   logic       init_done;

   modport master (
      output s_addr, s_en, s_wren, s_ren, s_wdata,
      input  s_rdata,
      input  tx_data, tx_valid,
      output tx_ready,
      output rx_data, rx_valid,
      input  rx_ready,
      input  clear_flags,
      output ovf_flags, init_done
   );

   modport slave (
      input  s_addr, s_en, s_wren, s_ren, s_wdata,
      output s_rdata,
      output tx_data, tx_valid,
      input  tx_ready,
      input  rx_data, rx_valid,
      output rx_ready,
      output clear_flags,
      input  ovf_flags, init_done
   );
endinterface

// File: rtl/serial_host_ctrl.sv
// Bus initiator for the 4-register RS-232 peripheral (data=0, status=1, div_l=2, div_h=3).
// Programs the baud divider once, then polls status and moves bytes between the
// peripheral and the tx/rx byte streams. All bus outputs are registered, so an
// access decided in a state becomes visible on the bus in the following cycle.
module serial_host_ctrl #(
   parameter logic [15:0] CLK_DIV      = 16'h0364,
   parameter int          READ_LATENCY = 2
) (
   input logic                 clk,
   input logic                 reset,
   serial_host_ctrl_if.master  bus
);

   localparam int                CNT_W    = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(READ_LATENCY - 1);

   localparam logic [1:0] A_DATA   = 2'd0;
   localparam logic [1:0] A_STATUS = 2'd1;
   localparam logic [1:0] A_DIV_L  = 2'd2;
   localparam logic [1:0] A_DIV_H  = 2'd3;

   typedef enum logic [2:0] {
      INIT_L, INIT_H, POLL, P_WAIT, DECIDE, RX_RD, R_WAIT, TX_WR
   } state_t;

   state_t           state_reg,     state_next;
   logic [CNT_W-1:0] cnt_reg,       cnt_next;
   logic [1:0]       stat_reg,      stat_next;      // {rx_ready, tx_ready} from last status read
   logic             last_rx_reg,   last_rx_next;   // 1: RX served last, 0: TX served last
   logic [7:0]       rx_data_reg,   rx_data_next;
   logic             rx_valid_reg,  rx_valid_next;
   logic [1:0]       ovf_reg,       ovf_next;
   logic             init_done_reg, init_done_next;
   logic [1:0]       s_addr_reg,    s_addr_next;
   logic             s_en_reg,      s_en_next;
   logic             s_wren_reg,    s_wren_next;
   logic             s_ren_reg,     s_ren_next;
   logic [7:0]       s_wdata_reg,   s_wdata_next;
   logic             tx_ready_reg,  tx_ready_next;

   logic rx_empty;
   logic rx_cand;
   logic tx_cand;

   // State and all registered outputs; async reset drops any buffered byte or in-flight access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= INIT_L;
         cnt_reg       <= '0;
         stat_reg      <= 2'b00;
         last_rx_reg   <= 1'b0;
         rx_data_reg   <= 8'h00;
         rx_valid_reg  <= 1'b0;
         ovf_reg       <= 2'b00;
         init_done_reg <= 1'b0;
         s_addr_reg    <= 2'b01;
         s_en_reg      <= 1'b0;
         s_wren_reg    <= 1'b0;
         s_ren_reg     <= 1'b0;
         s_wdata_reg   <= 8'h00;
         tx_ready_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         stat_reg      <= stat_next;
         last_rx_reg   <= last_rx_next;
         rx_data_reg   <= rx_data_next;
         rx_valid_reg  <= rx_valid_next;
         ovf_reg       <= ovf_next;
         init_done_reg <= init_done_next;
         s_addr_reg    <= s_addr_next;
         s_en_reg      <= s_en_next;
         s_wren_reg    <= s_wren_next;
         s_ren_reg     <= s_ren_next;
         s_wdata_reg   <= s_wdata_next;
         tx_ready_reg  <= tx_ready_next;
      end
   end

   // Next-state and next-output logic; strobes default low, address/data hold between accesses.
   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      stat_next      = stat_reg;
      last_rx_next   = last_rx_reg;
      rx_data_next   = rx_data_reg;
      rx_valid_next  = rx_valid_reg;
      ovf_next       = ovf_reg;
      init_done_next = init_done_reg;
      s_addr_next    = s_addr_reg;
      s_en_next      = 1'b0;
      s_wren_next    = 1'b0;
      s_ren_next     = 1'b0;
      s_wdata_next   = s_wdata_reg;
      tx_ready_next  = 1'b0;

      // a same-cycle consumer handshake frees the buffer for this DECIDE
      rx_empty = !rx_valid_reg || bus.rx_ready;
      rx_cand  = stat_reg[1] && rx_empty;
      tx_cand  = stat_reg[0] && bus.tx_valid;

      if (rx_valid_reg && bus.rx_ready) begin
         rx_valid_next = 1'b0;
      end

      // clear first so that a status capture below overrides it
      if (bus.clear_flags) begin
         ovf_next = 2'b00;
      end

      case (state_reg)
         INIT_L: begin
            s_en_next    = 1'b1;
            s_wren_next  = 1'b1;
            s_addr_next  = A_DIV_L;
            s_wdata_next = CLK_DIV[7:0];
            state_next   = INIT_H;
         end
         INIT_H: begin
            s_en_next    = 1'b1;
            s_wren_next  = 1'b1;
            s_addr_next  = A_DIV_H;
            s_wdata_next = CLK_DIV[15:8];
            state_next   = POLL;
         end
         POLL: begin
            init_done_next = 1'b1;
            s_en_next      = 1'b1;
            s_ren_next     = 1'b1;
            s_addr_next    = A_STATUS;
            cnt_next       = '0;
            state_next     = P_WAIT;
         end
         P_WAIT: begin
            if (cnt_reg == CNT_LAST) begin
               stat_next  = bus.s_rdata[3:2];
               ovf_next   = ovf_next | bus.s_rdata[1:0];
               state_next = DECIDE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DECIDE: begin
            if (rx_cand && tx_cand) begin
               state_next = last_rx_reg ? TX_WR : RX_RD;
            end else if (rx_cand) begin
               state_next = RX_RD;
            end else if (tx_cand) begin
               state_next = TX_WR;
            end else begin
               state_next = POLL;
            end
         end
         RX_RD: begin
            s_en_next   = 1'b1;
            s_ren_next  = 1'b1;
            s_addr_next = A_DATA;
            cnt_next    = '0;
            state_next  = R_WAIT;
         end
         R_WAIT: begin
            if (cnt_reg == CNT_LAST) begin
               rx_data_next  = bus.s_rdata;
               rx_valid_next = 1'b1;
               last_rx_next  = 1'b1;
               state_next    = POLL;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         TX_WR: begin
            // producer may have withdrawn the byte since DECIDE
            if (bus.tx_valid) begin
               s_en_next     = 1'b1;
               s_wren_next   = 1'b1;
               s_addr_next   = A_DATA;
               s_wdata_next  = bus.tx_data;
               tx_ready_next = 1'b1;
               last_rx_next  = 1'b0;
            end
            state_next = POLL;
         end
         default: begin
            state_next = INIT_L;
         end
      endcase
   end

   assign bus.s_addr    = s_addr_reg;
   assign bus.s_en      = s_en_reg;
   assign bus.s_wren    = s_wren_reg;
   assign bus.s_ren     = s_ren_reg;
   assign bus.s_wdata   = s_wdata_reg;
   assign bus.tx_ready  = tx_ready_reg;
   assign bus.rx_data   = rx_data_reg;
   assign bus.rx_valid  = rx_valid_reg;
   assign bus.ovf_flags = ovf_reg;
   assign bus.init_done = init_done_reg;

endmodule

// File: tb/tb_serial_host_ctrl.sv
// Testbench for serial_host_ctrl: a small peripheral model answers reads with
// registered data, and a vector table drives one poll round per entry.
module tb_serial_host_ctrl;

   localparam int K_POLL    = 0;
   localparam int K_RD      = 1;
   localparam int K_WR      = 2;
   localparam int K_OTHER   = 3;
   localparam int K_TIMEOUT = 4;
   localparam int NV        = 18;

   typedef struct {
      logic [7:0] status;
      logic [7:0] rdata;
      logic       tx_valid;
      logic [7:0] tx_data;
      logic       rx_ready;
      logic       clear;
      int         exp_kind;
      logic [7:0] exp_wdata;
      logic       exp_rx_valid;
      logic [7:0] exp_rx_data;
      logic [1:0] exp_ovf;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [7:0] status_val = 8'h00;
   logic [7:0] data_val = 8'h00;
   int tests = 0;
   int failed = 0;
   int txr_cnt = 0;
   int viol = 0;
   vec_t vecs [NV];

   serial_host_ctrl_if bus ();

   serial_host_ctrl #(
      .CLK_DIV      (16'h0364),
      .READ_LATENCY (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // peripheral model: registered read data, valid the cycle after the strobe
   always @(posedge clk) begin
      if (bus.s_en && bus.s_ren) begin
         bus.s_rdata <= (bus.s_addr == 2'd1) ? status_val : data_val;
      end
   end

   // protocol monitor
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.tx_ready) txr_cnt++;
         if ((bus.s_wren && bus.s_ren) || ((bus.s_wren || bus.s_ren) && !bus.s_en) ||
             (bus.tx_ready && !(bus.s_en && bus.s_wren && bus.s_addr == 2'd0)))
            viol++;
      end
   end

   // global time limit
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      failed++;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " bus"}, {bus.s_addr, bus.s_en, bus.s_wren, bus.s_ren, bus.s_wdata},
            {2'b01, 1'b0, 1'b0, 1'b0, 8'h00});
      check({tag, " rx"}, {bus.rx_valid, bus.rx_data, bus.tx_ready}, {1'b0, 8'h00, 1'b0});
      check({tag, " flags"}, {bus.ovf_flags, bus.init_done}, {2'b00, 1'b0});
   endtask

   // release reset at a falling edge and follow the divider writes and first poll
   task automatic run_init(input string tag);
      @(negedge clk);
      reset = 1'b0;
      check({tag, " c0"}, {bus.s_en, bus.init_done}, 2'b00);
      @(negedge clk);
      check({tag, " c1 wr div_l"}, {bus.s_en, bus.s_wren, bus.s_ren, bus.s_addr, bus.s_wdata, bus.init_done},
            {1'b1, 1'b1, 1'b0, 2'd2, 8'h64, 1'b0});
      $display("[TB] %s cycle1 write a%0d d%02h", tag, bus.s_addr, bus.s_wdata);
      @(negedge clk);
      check({tag, " c2 wr div_h"}, {bus.s_en, bus.s_wren, bus.s_ren, bus.s_addr, bus.s_wdata, bus.init_done},
            {1'b1, 1'b1, 1'b0, 2'd3, 8'h03, 1'b0});
      $display("[TB] %s cycle2 write a%0d d%02h", tag, bus.s_addr, bus.s_wdata);
      @(negedge clk);
      check({tag, " c3 poll"}, {bus.s_en, bus.s_wren, bus.s_ren, bus.s_addr, bus.init_done},
            {1'b1, 1'b0, 1'b1, 2'd1, 1'b1});
      $display("[TB] %s cycle3 read a%0d init_done=%0b", tag, bus.s_addr, bus.init_done);
   endtask

   // wait (bounded) for the next access strobe and classify it
   task automatic next_strobe(output int kind);
      kind = K_TIMEOUT;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.s_en) begin
            if (bus.s_ren && bus.s_addr == 2'd1)      kind = K_POLL;
            else if (bus.s_ren && bus.s_addr == 2'd0) kind = K_RD;
            else if (bus.s_wren && bus.s_addr == 2'd0) kind = K_WR;
            else                                       kind = K_OTHER;
            break;
         end
      end
   endtask

   initial begin
      int  kind;
      bit  abort;
      abort = 1'b0;
      bus.tx_data     = 8'h00;
      bus.tx_valid    = 1'b0;
      bus.rx_ready    = 1'b0;
      bus.clear_flags = 1'b0;

      //          status rdata  txv   txd    rxr   clr   kind    wdata  rxv   rxd    ovf
      vecs[0]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, K_POLL, 8'h00, 1'b0, 8'h00, 2'b00};
      vecs[1]  = '{8'h08, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, K_RD,   8'h00, 1'b1, 8'hA5, 2'b00};
      vecs[2]  = '{8'h08, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, K_POLL, 8'h00, 1'b1, 8'hA5, 2'b00};
      vecs[3]  = '{8'h04, 8'h11, 1'b1, 8'h3C, 1'b0, 1'b0, K_WR,   8'h3C, 1'b1, 8'hA5, 2'b00};
      vecs[4]  = '{8'h00, 8'h11, 1'b1, 8'h3C, 1'b1, 1'b0, K_POLL, 8'h00, 1'b0, 8'hA5, 2'b00};
      vecs[5]  = '{8'h0C, 8'h77, 1'b1, 8'h5A, 1'b1, 1'b0, K_RD,   8'h00, 1'b0, 8'h77, 2'b00};
      vecs[6]  = '{8'h0C, 8'h77, 1'b1, 8'h5B, 1'b1, 1'b0, K_WR,   8'h5B, 1'b0, 8'h77, 2'b00};
      vecs[7]  = '{8'h0C, 8'h78, 1'b1, 8'h5B, 1'b1, 1'b0, K_RD,   8'h00, 1'b0, 8'h78, 2'b00};
      vecs[8]  = '{8'h0C, 8'h78, 1'b1, 8'h5C, 1'b1, 1'b0, K_WR,   8'h5C, 1'b0, 8'h78, 2'b00};
      vecs[9]  = '{8'h03, 8'h78, 1'b0, 8'h00, 1'b0, 1'b0, K_POLL, 8'h00, 1'b0, 8'h78, 2'b11};
      vecs[10] = '{8'h00, 8'h78, 1'b0, 8'h00, 1'b0, 1'b0, K_POLL, 8'h00, 1'b0, 8'h78, 2'b11};
      vecs[11] = '{8'h00, 8'h78, 1'b0, 8'h00, 1'b0, 1'b1, K_POLL, 8'h00, 1'b0, 8'h78, 2'b00};
      vecs[12] = '{8'h03, 8'h78, 1'b0, 8'h00, 1'b0, 1'b0, K_POLL, 8'h00, 1'b0, 8'h78, 2'b11};
      vecs[13] = '{8'h01, 8'h78, 1'b0, 8'h00, 1'b0, 1'b1, K_POLL, 8'h00, 1'b0, 8'h78, 2'b01};
      vecs[14] = '{8'h88, 8'hC3, 1'b0, 8'h00, 1'b0, 1'b0, K_RD,   8'h00, 1'b1, 8'hC3, 2'b01};
      vecs[15] = '{8'h0C, 8'hC3, 1'b1, 8'h99, 1'b0, 1'b0, K_WR,   8'h99, 1'b1, 8'hC3, 2'b01};
      vecs[16] = '{8'h0C, 8'h44, 1'b0, 8'h00, 1'b1, 1'b0, K_RD,   8'h00, 1'b0, 8'h44, 2'b01};
      vecs[17] = '{8'h04, 8'h44, 1'b0, 8'h00, 1'b0, 1'b0, K_POLL, 8'h00, 1'b0, 8'h44, 2'b01};

      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      run_init("init");

      // each vector starts at the falling edge of a visible status-read strobe
      for (int i = 0; i < NV; i++) begin
         status_val      = vecs[i].status;
         data_val        = vecs[i].rdata;
         bus.tx_valid    = vecs[i].tx_valid;
         bus.tx_data     = vecs[i].tx_data;
         bus.rx_ready    = vecs[i].rx_ready;
         bus.clear_flags = vecs[i].clear;
         // clear spans exactly the status capture edge
         repeat (2) @(posedge clk);
         #1 bus.clear_flags = 1'b0;

         next_strobe(kind);
         check($sformatf("v%0d kind", i), kind, vecs[i].exp_kind);
         if (kind == K_WR) begin
            check($sformatf("v%0d wdata", i), bus.s_wdata, vecs[i].exp_wdata);
            check($sformatf("v%0d tx_ready", i), bus.tx_ready, 1'b1);
         end
         if (kind == K_TIMEOUT) begin
            abort = 1'b1;
            break;
         end
         if (kind != K_POLL) begin
            next_strobe(kind);
            check($sformatf("v%0d repoll", i), kind, K_POLL);
            if (kind != K_POLL) begin
               abort = 1'b1;
               break;
            end
         end
         check($sformatf("v%0d rx", i), {bus.rx_valid, bus.rx_data}, {vecs[i].exp_rx_valid, vecs[i].exp_rx_data});
         check($sformatf("v%0d ovf", i), bus.ovf_flags, vecs[i].exp_ovf);
         check($sformatf("v%0d tx_ready idle", i), bus.tx_ready, 1'b0);
         $display("[TB] v%0d status=%02h kind=%0d rx_valid=%0b rx_data=%02h ovf=%02b",
                  i, vecs[i].status, kind, bus.rx_valid, bus.rx_data, bus.ovf_flags);
      end

      if (!abort) begin
         check("tx_ready pulses", txr_cnt, 4);

         // reset while the data-register read is in flight
         status_val   = 8'h08;
         data_val     = 8'h5E;
         bus.tx_valid = 1'b0;
         bus.rx_ready = 1'b0;
         repeat (2) @(posedge clk);
         next_strobe(kind);
         check("rst rd issued", kind, K_RD);
         reset = 1'b1;
         #1;
         check_reset_vals("midreset");
         $display("[TB] reset during data read: s_en=%0b rx_valid=%0b init_done=%0b",
                  bus.s_en, bus.rx_valid, bus.init_done);
         repeat (2) @(negedge clk);
         run_init("reinit");
      end

      check("protocol violations", viol, 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
